// File: rtl/mem_stage_pkg.sv
// Shared constants, state encoding and access-legality helpers for the memory stage.
// The optional bus timeout is enabled with the MEM_STAGE_TIMEOUT_EN macro.
package mem_stage_pkg;

  localparam int DATA_W             = 32;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational byte-lane steering: store enables/replication and load extraction/extension.
// Shared by the store path (request setup) and the load path (response capture).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    logic signed [DATA_W-1:0] ext;
    ext = b;
    return ext;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    logic signed [DATA_W-1:0] ext;
    ext = h;
    return ext;
  endfunction

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unsigned sizes share the lane pattern of their signed counterparts.
  always_comb begin
    be       = 4'b0000;
    wdata    = '0;
    load_val = '0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
        load_val = (funct3 == F3_B) ? sext8(byte_sel) : {24'd0, byte_sel};
      end
      F3_H, F3_HU: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
        load_val = (funct3 == F3_H) ? sext16(half_sel) : {16'd0, half_sel};
      end
      F3_W: begin
        be       = 4'b1111;
        wdata    = store_data;
        load_val = rdata;
      end
      default: begin
        be       = 4'b0000;
        wdata    = '0;
        load_val = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: validates the request, runs one valid/ready bus access, and reports
// result, next PC and fault with a done pulse. Optional bus timeout: MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic              zero,
  input  logic              is_branch,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] pc_value,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] next_pc,
  output logic              fault
);

  state_t            state;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic              is_load_q;

  logic [2:0]        f3_sel;
  logic [1:0]        addr_lo_sel;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_c;

  logic              mem_op;
  logic              req_bad;
  logic              timeout_hit;

  // In IDLE the aligner sees the incoming request; afterwards it sees the latched one.
  assign f3_sel      = (state == IDLE) ? funct3 : funct3_q;
  assign addr_lo_sel = (state == IDLE) ? alu_res[1:0] : addr_lo_q;

  assign mem_op  = mem_read | mem_write;
  assign req_bad = (mem_read & mem_write) | is_illegal_f3(funct3) |
                   is_misaligned(funct3, alu_res[1:0]);

  mem_lane_align u_align (
    .funct3     (f3_sel),
    .addr_lo    (addr_lo_sel),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_val   (load_c)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [31:0] timeout_cnt;

  assign timeout_hit = !mem_ready && (timeout_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (state == ACCESS && !mem_ready && !timeout_hit) begin
      timeout_cnt <= timeout_cnt + 32'd1;
    end else begin
      timeout_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      is_load_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      next_pc   <= '0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            funct3_q  <= funct3;
            addr_lo_q <= alu_res[1:0];
            is_load_q <= mem_read;
            result    <= alu_res;
            next_pc   <= (is_branch && zero) ? branch_target : pc_value + 32'd4;
            if (!mem_op) begin
              state <= RESP;
              done  <= 1'b1;
              fault <= 1'b0;
            end else if (req_bad) begin
              state <= RESP;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state     <= ACCESS;
              busy      <= 1'b1;
              fault     <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {alu_res[DATA_W-1:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end
        end

        ACCESS: begin
          if (mem_ready || timeout_hit) begin
            state     <= RESP;
            busy      <= 1'b0;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (mem_ready) begin
              if (is_load_q) result <= load_c;
            end else begin
              fault  <= 1'b1;
              result <= '0;
            end
          end
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-instruction vectors plus hand-written
// sequences for reset, ignored start/ready, reset mid-access and the optional timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] alu_res, store_data, branch_target, pc_value, mem_rdata;
  logic        mem_read, mem_write, zero, is_branch, mem_ready;
  logic [2:0]  funct3;
  logic        mem_req, mem_we, busy, done, fault;
  logic [31:0] mem_addr, mem_wdata, result, next_pc;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_res(alu_res), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .zero(zero),
    .is_branch(is_branch), .branch_target(branch_target), .pc_value(pc_value),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .result(result), .next_pc(next_pc), .fault(fault)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic        zero;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          waits;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] res;
    logic [31:0] npc;
    logic        flt;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] alu, input logic [31:0] sd, input logic rd, input logic wr,
    input logic [2:0] f3, input logic z, input logic br, input logic [31:0] tgt,
    input logic [31:0] pc, input logic [31:0] rdata, input int waits,
    input logic req, input logic we, input logic [31:0] addr, input logic [3:0] be,
    input logic [31:0] wdata, input logic [31:0] res, input logic [31:0] npc,
    input logic flt, input int lat);
    vec_t v;
    v.alu = alu; v.sd = sd; v.rd = rd; v.wr = wr; v.f3 = f3; v.zero = z; v.br = br;
    v.tgt = tgt; v.pc = pc; v.rdata = rdata; v.waits = waits; v.req = req; v.we = we;
    v.addr = addr; v.be = be; v.wdata = wdata; v.res = res; v.npc = npc; v.flt = flt;
    v.lat = lat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    alu_res = v.alu; store_data = v.sd; mem_read = v.rd; mem_write = v.wr;
    funct3 = v.f3; zero = v.zero; is_branch = v.br; branch_target = v.tgt;
    pc_value = v.pc;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, waits;
    bit seen_done, seen_req, bus_bad, busy_bad;
    logic busy_at_done, we_f;
    logic [31:0] addr_f, wdata_f;
    logic [3:0]  be_f;
    cyc = 0; waits = 0; seen_done = 0; seen_req = 0; bus_bad = 0; busy_bad = 0;
    busy_at_done = 1'b0; we_f = 1'b0; addr_f = '0; wdata_f = '0; be_f = '0;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!seen_done && cyc <= 40) begin
      mem_ready = 1'b0;
      mem_rdata = 32'hA5A5A5A5;
      if (done) begin
        seen_done = 1;
        busy_at_done = busy;
      end else begin
        if (mem_req) begin
          if (!seen_req) begin
            seen_req = 1; we_f = mem_we; addr_f = mem_addr; be_f = mem_be; wdata_f = mem_wdata;
          end else if (mem_we !== we_f || mem_addr !== addr_f || mem_be !== be_f ||
                       mem_wdata !== wdata_f) begin
            bus_bad = 1;
          end
          if (busy !== 1'b1) busy_bad = 1;
          if (waits == v.waits) begin
            mem_ready = 1'b1;
            mem_rdata = v.rdata;
          end else begin
            waits++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b0;
    check($sformatf("v%0d_done_seen", idx), 32'(seen_done), 32'd1);
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.lat));
    check($sformatf("v%0d_req_seen", idx), 32'(seen_req), 32'(v.req));
    check($sformatf("v%0d_result", idx), result, v.res);
    check($sformatf("v%0d_next_pc", idx), next_pc, v.npc);
    check($sformatf("v%0d_fault", idx), 32'(fault), 32'(v.flt));
    check($sformatf("v%0d_busy_at_done", idx), 32'(busy_at_done), 32'd0);
    if (v.req) begin
      check($sformatf("v%0d_we", idx), 32'(we_f), 32'(v.we));
      check($sformatf("v%0d_addr", idx), addr_f, v.addr);
      check($sformatf("v%0d_be", idx), 32'(be_f), 32'(v.be));
      check($sformatf("v%0d_wdata", idx), wdata_f, v.wdata);
      check($sformatf("v%0d_bus_stable", idx), 32'(bus_bad), 32'd0);
      check($sformatf("v%0d_busy_in_access", idx), 32'(busy_bad), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_next_pc"}, next_pc, 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    vec_t sv;
    int cnt, req_cnt;
    bit seen;

    //              alu           sd           rd wr f3     z  br tgt          pc           rdata        w  req we addr        be       wdata        res          npc          f  lat
    vecs[0]  = mk(32'h1234,     32'h0,       0, 0, 3'b000, 1, 1, 32'h80,      32'h40,      32'h0,       0, 0, 0, 32'h0,      4'b0000, 32'h0,       32'h1234,     32'h80,      0, 1);
    vecs[1]  = mk(32'h103,      32'hAB,      0, 1, 3'b000, 0, 0, 32'h80,      32'h40,      32'h0,       3, 1, 1, 32'h100,    4'b1000, 32'hABABABAB, 32'h103,     32'h44,      0, 5);
    vecs[2]  = mk(32'h202,      32'h0,       1, 0, 3'b000, 0, 0, 32'h0,       32'h40,      32'h00800000, 0, 1, 0, 32'h200,   4'b0100, 32'h0,       32'hFFFFFF80, 32'h44,      0, 2);
    vecs[3]  = mk(32'h202,      32'h0,       1, 0, 3'b100, 0, 0, 32'h0,       32'h40,      32'h00800000, 0, 1, 0, 32'h200,   4'b0100, 32'h0,       32'h00000080, 32'h44,      0, 2);
    vecs[4]  = mk(32'h6,        32'h0,       1, 0, 3'b010, 0, 0, 32'h0,       32'h48,      32'h0,       0, 0, 0, 32'h0,      4'b0000, 32'h0,       32'h6,        32'h4C,      1, 1);
    vecs[5]  = mk(32'h102,      32'h0,       1, 0, 3'b001, 0, 0, 32'h0,       32'h50,      32'h80010000, 1, 1, 0, 32'h100,   4'b1100, 32'h0,       32'hFFFF8001, 32'h54,      0, 3);
    vecs[6]  = mk(32'h100,      32'h0,       1, 0, 3'b101, 0, 0, 32'h0,       32'h50,      32'h1234F00D, 0, 1, 0, 32'h100,   4'b0011, 32'h0,       32'h0000F00D, 32'h54,      0, 2);
    vecs[7]  = mk(32'h2,        32'h1234BEEF, 0, 1, 3'b001, 0, 0, 32'h0,      32'h60,      32'h0,       1, 1, 1, 32'h0,      4'b1100, 32'hBEEFBEEF, 32'h2,       32'h64,      0, 3);
    vecs[8]  = mk(32'h10,       32'hDEADBEEF, 0, 1, 3'b010, 0, 1, 32'h999,    32'h100,     32'h0,       2, 1, 1, 32'h10,     4'b1111, 32'hDEADBEEF, 32'h10,      32'h104,     0, 4);
    vecs[9]  = mk(32'h20,       32'h0,       1, 0, 3'b010, 1, 1, 32'h300,     32'h200,     32'hCAFEF00D, 0, 1, 0, 32'h20,    4'b1111, 32'h0,       32'hCAFEF00D, 32'h300,     0, 2);
    vecs[10] = mk(32'h0,        32'h0,       1, 0, 3'b011, 0, 0, 32'h0,       32'h10,      32'h0,       0, 0, 0, 32'h0,      4'b0000, 32'h0,       32'h0,        32'h14,      1, 1);
    vecs[11] = mk(32'h40,       32'h0,       1, 1, 3'b010, 0, 0, 32'h0,       32'h10,      32'h0,       0, 0, 0, 32'h0,      4'b0000, 32'h0,       32'h40,       32'h14,      1, 1);
    vecs[12] = mk(32'h101,      32'h5555,    0, 1, 3'b001, 0, 0, 32'h0,       32'h10,      32'h0,       0, 0, 0, 32'h0,      4'b0000, 32'h0,       32'h101,      32'h14,      1, 1);
    vecs[13] = mk(32'h1,        32'h0,       1, 0, 3'b000, 0, 0, 32'h0,       32'h70,      32'h00007F00, 0, 1, 0, 32'h0,     4'b0010, 32'h0,       32'h0000007F, 32'h74,      0, 2);
    vecs[14] = mk(32'hABC,      32'h0,       0, 0, 3'b111, 1, 0, 32'h500,     32'h70,      32'h0,       0, 0, 0, 32'h0,      4'b0000, 32'h0,       32'hABC,      32'h74,      0, 1);

    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // mem_ready while idle must not produce anything
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    check("idle_ready_done", 32'(done), 32'd0);
    check("idle_ready_req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // done is a single-cycle pulse and outputs hold afterwards
    @(negedge clk);
    check("done_pulse_low", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("hold_result", result, 32'hABC);
    check("hold_next_pc", next_pc, 32'h74);

    // start during ACCESS is ignored
    sv = mk(32'h30, 32'h0, 1, 0, 3'b010, 0, 0, 32'h0, 32'h80, 32'h0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(sv);
    start = 1'b1;
    @(negedge clk);
    alu_res = 32'h5554; mem_read = 1'b0; pc_value = 32'h900;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_addr", mem_addr, 32'h30);
    check("ign_start_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_ready = 1'b0;
    check("ign_start_done", 32'(done), 32'd1);
    check("ign_start_result", result, 32'h11223344);
    check("ign_start_npc", next_pc, 32'h84);

    // reset in the middle of an access; a late ready is dropped
    @(negedge clk);
    sv = mk(32'h44, 32'h77, 0, 1, 3'b010, 0, 0, 32'h0, 32'hA0, 32'h0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(sv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_mid");
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check("rst_mid_late_ready_done", 32'(cnt), 32'd0);

    // ready tied low
    sv = mk(32'h40, 32'h0, 1, 0, 3'b010, 0, 0, 32'h0, 32'hC0, 32'h0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(sv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    req_cnt = 0; seen = 0; cnt = 1;
    while (!seen && cnt <= 20) begin
      if (done) seen = 1;
      else begin
        if (mem_req) req_cnt++;
        @(negedge clk);
        cnt++;
      end
    end
`ifdef MEM_STAGE_TIMEOUT_EN
    check("timeout_done_seen", 32'(seen), 32'd1);
    check("timeout_req_cycles", 32'(req_cnt), 32'd4);
    check("timeout_latency", 32'(cnt), 32'd5);
    check("timeout_fault", 32'(fault), 32'd1);
    check("timeout_result", result, 32'd0);
    check("timeout_req_dropped", 32'(mem_req), 32'd0);
`else
    check("no_timeout_done", 32'(seen), 32'd0);
    check("no_timeout_req_held", 32'(mem_req), 32'd1);
    check("no_timeout_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("wait_rst");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage downstream of the execution stage in the no-pipeline core.
- Consumes the EX outputs: ALU result as address, second-register value as store data, zero flag, branch target.
- Performs byte/half/word loads and stores over a valid/ready data-memory bus, then computes the next PC and reports completion to the core sequencer.
- Multi-cycle; the core holds until done.

Parameters:
- TIMEOUT_CYCLES, 64: cycles of mem_req without mem_ready before a timeout fault. Used only with MEM_STAGE_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; EX outputs valid, begin operation
- alu_res  in  32  ALU result: effective address, or writeback value for non-memory ops
- store_data  in  32  rs2 value for stores
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- zero  in  1  ALU zero flag
- is_branch  in  1  branch instruction
- branch_target  in  32  PC + B-immediate
- pc_value  in  32  PC of current instruction
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, alu_res with [1:0] cleared
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  bus accepted/completed the access this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1 and mem_we=0
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  32  load data (loads) or latched alu_res (all others)
- next_pc  out  32  branch_target if is_branch&zero, else pc_value+4
- fault  out  1  valid with done: misaligned, illegal funct3, read&write together, or timeout

Behaviour:
- Reset: state IDLE; every output 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy, done, result, next_pc, fault). Timeout counter 0.
- IDLE, start=1: latch all inputs. Compute next_pc from the latched values.
  - Checks: misaligned is H with addr[0]=1, or W with addr[1:0]≠0. Illegal funct3 is 011/110/111 when a memory op is requested.
  - No memory op -> RESP, fault=0.
  - Check failure or mem_read&mem_write -> RESP, fault=1, no bus request.
  - Otherwise -> ACCESS.
- ACCESS:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ready.
  - mem_ready=1 on a load: capture the extracted mem_rdata into result.
  - mem_ready=1 on any op: mem_req drops next cycle -> RESP.
- RESP: done=1, busy=0 for one cycle -> IDLE. result, next_pc and fault hold until the next start.
- busy=1 in ACCESS, and for the cycle following an accepted start.
- start while not IDLE: ignored.
- Latency, counted from the start cycle N:
  - Non-memory op or fault: done at N+1.
  - Memory op: mem_req at N+1; done one cycle after the first mem_ready. Minimum done at N+2.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{b}}.
  - SH: be=0011 or 1100 by addr[1], wdata={2{h}}.
  - SW: be=1111.
- Load lanes: select by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. For loads mem_be reflects the accessed bytes.
- mem_ready while mem_req=0: ignored.
- rst in any state: next edge returns to IDLE with all outputs 0. An in-flight bus response is dropped.

Optional Feature:
- MEM_STAGE_TIMEOUT_EN defined:
  - Counter increments each ACCESS cycle with mem_ready=0.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to RESP with fault=1, result=0.
  - Counter clears on leaving ACCESS.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package mem_stage_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, ACCESS, RESP.
  - Default TIMEOUT_CYCLES.
- Sub-module mem_lane_align: purely combinational; produces mem_be, mem_wdata and the extracted/extended load value from funct3, addr[1:0] and the raw data.

Test Plan:
- Non-memory op, alu_res=0x1234, is_branch=1, zero=1, branch_target=0x80, pc_value=0x40 -> done at N+1, result=0x1234, next_pc=0x80, no mem_req.
- SB addr=0x103, store_data=0xAB, mem_ready after 3 wait cycles -> mem_addr=0x100, be=1000, wdata=0xABABABAB held stable, done one cycle after ready, next_pc=0x44.
- LB addr=0x202, rdata=0x00800000, immediate ready -> result=0xFFFFFF80. Same with LBU -> result=0x00000080. done at N+2.
- LW addr=0x6 -> done at N+1, fault=1, mem_req never asserted.
- rst during ACCESS with mem_req=1 -> next cycle all outputs 0. A late mem_ready causes no done.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready tied 0 -> mem_req high 4 cycles, then done with fault=1, result=0.
